// File: rtl/chad_stack_pkg.sv
// Shared constants for the shift-register stack and its spill extension:
// the EMPTY fill pattern, the delta push/pop codes, and the depth-width helper.
package chad_stack_pkg;

  // Pattern shifted in when nothing is stored below; truncate to the cell width.
  localparam logic [31:0] EMPTY = 32'h55AA55AA;

  // Delta encoding: 01 = push, 11 = pop, x0 = no move.
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;

  // Width of the total-depth counter (on-chip tail + top + spill store).
  function automatic int depth_w(input int depth, input int ext_depth);
    return $clog2(depth + 1 + ext_depth + 1);
  endfunction

endpackage

// File: rtl/spill_ram.sv
// Spill store body: ENTRIES cells, synchronous write, asynchronous read.
// Holds every spilled cell except the newest, which lives in fill_reg.
module spill_ram #(
  parameter int WIDTH   = 18,
  parameter int ENTRIES = 63,
  parameter int AW      = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  // Write port: no reset, contents are logically discarded by the owner's counters.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read port is combinational so a pop can refill fill_reg in one cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_spill.sv
// Spill/fill extension for the shift-register stack. Cells pushed off the
// bottom of a full on-chip stack are saved here and returned on pops.
// Optional macro STACK_SPILL_HWM_EN adds output hwm: maximum depth reached
// since reset or the last clr.
module stack_spill
  import chad_stack_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int DEPTH     = 16,
  parameter int EXT_DEPTH = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   hold,
  input  logic [1:0]                             delta,
  input  logic [WIDTH-1:0]                       spill_in,
  output logic [WIDTH-1:0]                       fill_out,
  output logic [depth_w(DEPTH, EXT_DEPTH)-1:0]   depth,
  output logic                                   ovf,
  output logic                                   unf,
`ifdef STACK_SPILL_HWM_EN
  output logic [depth_w(DEPTH, EXT_DEPTH)-1:0]   hwm,
`endif
  input  logic                                   clr
);

  localparam int DW = depth_w(DEPTH, EXT_DEPTH);
  localparam int EW = $clog2(EXT_DEPTH + 1);
  localparam int AW = $clog2(EXT_DEPTH);
  localparam logic [DW-1:0]    OC_FULL  = DW'(DEPTH + 1);
  localparam logic [EW-1:0]    EXT_FULL = EW'(EXT_DEPTH);
  localparam logic [WIDTH-1:0] EMPTY_W  = WIDTH'(EMPTY);

  logic [DW-1:0]    depth_q, depth_nxt, oc;
  logic [EW-1:0]    ext_count, ext_nxt;
  logic [WIDTH-1:0] fill_reg, fill_nxt, rd_data;
  logic             ovf_q, unf_q, ovf_ev, unf_ev, wr_en;
  logic             push, pop, clr_eff;
  logic [AW-1:0]    wr_addr, rd_addr;

  // hold masks every command, including clr.
  assign push    = !hold && (delta == DELTA_PUSH);
  assign pop     = !hold && (delta == DELTA_POP);
  assign clr_eff = !hold && clr;

  assign oc      = depth_q - DW'(ext_count);
  assign wr_addr = AW'(ext_count - EW'(1));
  assign rd_addr = AW'(ext_count - EW'(2));

  spill_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (EXT_DEPTH - 1),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (fill_reg),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state: spill only once the on-chip stack is full, fill before draining on-chip cells.
  always_comb begin
    depth_nxt = depth_q;
    ext_nxt   = ext_count;
    fill_nxt  = fill_reg;
    wr_en     = 1'b0;
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    if (push) begin
      if (oc < OC_FULL) begin
        depth_nxt = depth_q + DW'(1);
      end else if (ext_count < EXT_FULL) begin
        wr_en     = (ext_count != '0);
        fill_nxt  = spill_in;
        ext_nxt   = ext_count + EW'(1);
        depth_nxt = depth_q + DW'(1);
      end else begin
        ovf_ev = 1'b1;
      end
    end else if (pop) begin
      if (ext_count != '0) begin
        fill_nxt  = (ext_count == EW'(1)) ? EMPTY_W : rd_data;
        ext_nxt   = ext_count - EW'(1);
        depth_nxt = depth_q - DW'(1);
      end else if (depth_q != '0) begin
        depth_nxt = depth_q - DW'(1);
      end else begin
        unf_ev = 1'b1;
      end
    end
  end

  // State register; a same-cycle overflow/underflow event wins over clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q   <= '0;
      ext_count <= '0;
      fill_reg  <= EMPTY_W;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      depth_q   <= depth_nxt;
      ext_count <= ext_nxt;
      fill_reg  <= fill_nxt;
      ovf_q     <= ovf_ev | (ovf_q & ~clr_eff);
      unf_q     <= unf_ev | (unf_q & ~clr_eff);
    end
  end

`ifdef STACK_SPILL_HWM_EN
  logic [DW-1:0] hwm_q;

  // High-water mark restarts from the current depth on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hwm_q <= '0;
    else if (clr_eff)           hwm_q <= depth_nxt;
    else if (depth_nxt > hwm_q) hwm_q <= depth_nxt;
  end

  assign hwm = hwm_q;
`endif

  assign fill_out = (ext_count != '0) ? fill_reg : EMPTY_W;
  assign depth    = depth_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_stack_spill.sv
// Bench for stack_spill (WIDTH=18, DEPTH=16, EXT_DEPTH=4): table vectors,
// hand-written corner sequences and random traffic against a queue model.
module tb_stack_spill;
  import chad_stack_pkg::*;

  localparam int WIDTH     = 18;
  localparam int DEPTH     = 16;
  localparam int EXT_DEPTH = 4;
  localparam int DW        = 5;  // clog2(16+1+4+1)
  localparam logic [WIDTH-1:0] EMPTY_C = 18'h255AA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic clr = 1'b0;
  logic [1:0] delta = 2'b00;
  logic [WIDTH-1:0] spill_in = '0;
  logic [WIDTH-1:0] fill_out;
  logic [DW-1:0] depth;
  logic ovf, unf;
`ifdef STACK_SPILL_HWM_EN
  logic [DW-1:0] hwm;
`endif

  always #5 clk = ~clk;

  stack_spill #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXT_DEPTH(EXT_DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .delta    (delta),
    .spill_in (spill_in),
    .fill_out (fill_out),
    .depth    (depth),
    .ovf      (ovf),
    .unf      (unf),
`ifdef STACK_SPILL_HWM_EN
    .hwm      (hwm),
`endif
    .clr      (clr)
  );

  // ---------------- reference model ----------------
  // Logical stack: total depth plus a queue of cells that went off-chip.
  int m_depth;
  logic [WIDTH-1:0] m_spilled[$];
  bit m_ovf, m_unf;
  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_depth = 0;
    m_spilled.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit h, input logic [1:0] d, input bit c, input logic [WIDTH-1:0] s);
    bit ov, un;
    ov = 0;
    un = 0;
    if (h) return;
    if (d == 2'b01) begin
      if (m_depth - m_spilled.size() < DEPTH + 1) m_depth++;
      else if (m_spilled.size() < EXT_DEPTH) begin
        m_spilled.push_back(s);
        m_depth++;
      end else ov = 1;
    end else if (d == 2'b11) begin
      if (m_spilled.size() > 0) begin
        void'(m_spilled.pop_back());
        m_depth--;
      end else if (m_depth > 0) m_depth--;
      else un = 1;
    end
    if (c) begin
      m_ovf = 0;
      m_unf = 0;
    end
    m_ovf = m_ovf | ov;
    m_unf = m_unf | un;
  endtask

  function automatic logic [WIDTH-1:0] model_fill();
    return (m_spilled.size() > 0) ? m_spilled[m_spilled.size()-1] : EMPTY_C;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int ed, input logic [WIDTH-1:0] ef,
                       input bit eo, input bit eu);
    n_vec++;
    if (depth !== DW'(ed) || fill_out !== ef || ovf !== eo || unf !== eu) begin
      n_err++;
      $display("FAIL %s: got depth=%0d fill=%h ovf=%b unf=%b, want depth=%0d fill=%h ovf=%b unf=%b",
               name, depth, fill_out, ovf, unf, ed, ef, eo, eu);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_depth, model_fill(), m_ovf, m_unf);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic apply(input bit h, input logic [1:0] d, input bit c, input logic [WIDTH-1:0] s);
    hold = h;
    delta = d;
    clr = c;
    spill_in = s;
    model_step(h, d, c, s);
    @(posedge clk);
    #1;
    hold = 0;
    delta = 2'b00;
    clr = 0;
  endtask

  typedef struct {
    logic hold;
    logic [1:0] delta;
    logic clr;
    logic [WIDTH-1:0] spill;
    int exp_depth;
    logic [WIDTH-1:0] exp_fill;
    logic exp_ovf;
    logic exp_unf;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // Table: 17 pushes stay on-chip, 18th spills 0x00ABC, a pop fills it back.
    for (int k = 1; k <= 17; k++)
      tbl[k-1] = '{1'b0, 2'b01, 1'b0, WIDTH'(k), k, EMPTY_C, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 2'b01, 1'b0, 18'h00ABC, 18, 18'h00ABC, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 2'b11, 1'b0, 18'h3FFFF, 17, EMPTY_C, 1'b0, 1'b0};

    model_reset();
    #1;
    check("reset_state", 0, EMPTY_C, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].hold, tbl[i].delta, tbl[i].clr, tbl[i].spill);
      check($sformatf("table_%0d", i), tbl[i].exp_depth, tbl[i].exp_fill,
            tbl[i].exp_ovf, tbl[i].exp_unf);
    end

    // Drain to empty, then underflow / clr / clr-with-underflow.
    for (int k = 0; k < 17; k++) apply(0, 2'b11, 0, '0);
    check("drain_to_zero", 0, EMPTY_C, 0, 0);
    apply(0, 2'b11, 0, '0);
    check("pop_at_zero_unf", 0, EMPTY_C, 0, 1);
    apply(0, 2'b00, 1, '0);
    check("clr_unf", 0, EMPTY_C, 0, 0);
    apply(0, 2'b11, 1, '0);
    check("clr_with_unf_event", 0, EMPTY_C, 0, 1);
    apply(0, 2'b00, 1, '0);

    // 22 pushes with EXT_DEPTH=4: spills carry 1..4, the 22nd overflows.
    for (int k = 1; k <= 22; k++)
      apply(0, 2'b01, 0, (k > 17) ? WIDTH'(k - 17) : 18'h15555);
    check("overflow_full", 21, 18'd4, 1, 0);
    for (int k = 3; k >= 1; k--) begin
      apply(0, 2'b11, 0, '0);
      check($sformatf("fill_seq_%0d", k), 21 - (4 - k), WIDTH'(k), 1, 0);
    end
    apply(0, 2'b11, 0, '0);
    check("fill_seq_empty", 17, EMPTY_C, 1, 0);
    apply(1, 2'b00, 1, '0);
    check("hold_masks_clr", 17, EMPTY_C, 1, 0);
    apply(0, 2'b00, 1, '0);
    check("clr_ovf", 17, EMPTY_C, 0, 0);

    // Hold with push for 5 cycles, then a no-move code 10.
    for (int k = 0; k < 5; k++) begin
      apply(1, 2'b01, 0, 18'h1234);
      check($sformatf("hold_%0d", k), 17, EMPTY_C, 0, 0);
    end
    apply(0, 2'b10, 0, 18'h1234);
    check("nomove_10", 17, EMPTY_C, 0, 0);

    // Random traffic biased toward push so the spill store fills and overflows.
    for (int k = 0; k < 600; k++) begin
      int r;
      logic [1:0] d;
      r = $urandom_range(0, 99);
      d = (r < 50) ? 2'b01 : (r < 82) ? 2'b11 : ((r & 1) ? 2'b10 : 2'b00);
      apply(($urandom_range(0, 7) == 0), d, ($urandom_range(0, 15) == 0),
            WIDTH'($urandom));
      check_model($sformatf("rand_%0d", k));
    end

`ifdef STACK_SPILL_HWM_EN
    apply(0, 2'b00, 1, '0);
    while (m_depth > 0) apply(0, 2'b11, 0, '0);
    apply(0, 2'b00, 1, '0);
    for (int k = 0; k < 20; k++) apply(0, 2'b01, 0, WIDTH'(k));
    for (int k = 0; k < 17; k++) apply(0, 2'b11, 0, '0);
    n_vec++;
    if (hwm !== DW'(20)) begin
      n_err++;
      $display("FAIL hwm_peak: got %0d want 20", hwm);
    end
    apply(0, 2'b00, 1, '0);
    n_vec++;
    if (hwm !== DW'(3)) begin
      n_err++;
      $display("FAIL hwm_clr: got %0d want 3", hwm);
    end
`endif

    // Asynchronous reset in the middle of a push with cells spilled.
    while (m_depth < 19) apply(0, 2'b01, 0, 18'h2BEEF);
    delta = 2'b01;
    spill_in = 18'h00777;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 0, EMPTY_C, 0, 0);
    delta = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(0, 2'b11, 0, '0);
    check("after_reset_pop", 0, EMPTY_C, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
